mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, SHALL set the busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10, SHALL set the busy cycles for div/divu.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1, SHALL be the E-stage MDU enable from the main decoder.
REQ-006 Port op, input, 3, SHALL be the MDU operation code: none/mult/multu/div/divu/mthi/mtlo.
REQ-007 Port rs_val, input, 32, SHALL be the forwarded rs operand (dividend, multiplicand, mthi/mtlo source).
REQ-008 Port rt_val, input, 32, SHALL be the forwarded rt operand (divisor, multiplier).
REQ-009 Port flush, input, 1, SHALL be the exception/interrupt cancel for the E-stage instruction.
REQ-010 Port d_uses_mdu, input, 1, SHALL mean the D-stage instruction is an MDU op or mfhi/mflo.
REQ-011 Port busy, output, 1, SHALL mean a mult/div is in progress.
REQ-012 Port stall_req, output, 1, SHALL request a D-stage stall.
REQ-013 Ports hi and lo, output, 32 each, SHALL show the architectural HI and LO registers.

Function
REQ-014 A start is accepted when start=1, flush=0, busy=0 and op is not none; otherwise it SHALL be ignored with no state change.
REQ-015 Accepted mult/multu/div/divu SHALL latch the result into internal pending registers at the accepting edge.
- mult: signed 64-bit product.
- multu: unsigned 64-bit product.
- div: signed; LO=quotient, HI=remainder; truncate toward zero; remainder takes the dividend's sign.
- divu: unsigned.
REQ-016 FSM SHALL have states IDLE and BUSY, plus a 4-bit down-counter.
- Accepted mult/div: IDLE->BUSY; counter loaded with MULT_LAT-1 or DIV_LAT-1.
- BUSY with counter nonzero: decrement.
- BUSY with counter zero: commit pending values to HI/LO and go to IDLE on that edge.
REQ-017 With start accepted in cycle 0, busy SHALL be 1 in cycles 1..LAT and 0 from cycle LAT+1. New HI/LO SHALL be visible from cycle LAT+1.
REQ-018 Accepted mthi/mtlo SHALL write HI/LO at the accepting edge (visible in cycle 1), leave the other register unchanged, and never assert busy.
REQ-019 div/divu with rt_val=0 SHALL run the full DIV_LAT busy period and then leave HI and LO unchanged.
REQ-020 flush asserted while BUSY SHALL NOT cancel the operation; the instruction has already issued.
REQ-021 stall_req SHALL be combinational: d_uses_mdu & (busy | (start & ~flush & op is mult/multu/div/divu)).
REQ-022 hi/lo SHALL be register outputs; no combinational path from any input to hi/lo.

Reset
REQ-023 reset_n=0 SHALL immediately force IDLE, counter=0, busy=0, hi=0, lo=0 and pending=0, including mid-operation.
REQ-024 After reset_n rises, the first accepted start SHALL behave exactly as in REQ-014..REQ-019.

Structure
REQ-025 The op encodings SHALL live in the shared define header, alongside the decoder's MDU control codes, so the decoder and mdu_ctrl share a single source. Encodings: none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6.
REQ-026 State encodings and the latency defaults SHALL also live in that header.
REQ-027 One combinational sub-module, mdu_arith, SHALL compute the 64-bit {HI,LO} result from op, rs_val and rt_val; the FSM, counter and registers stay in mdu_ctrl.

Verification
REQ-028 mult, rs=0xFFFFFFFF, rt=0x00000002 -> busy cycles 1..5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
REQ-029 multu, same operands -> cycle 6: HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div, rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy cycles 1..10; cycle 11: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 divu by zero with HI=0x11, LO=0x22 -> busy cycles 1..10; cycle 11: HI=0x11, LO=0x22.
REQ-032 mthi with rs=0x1234 and flush=0 -> HI=0x1234 in cycle 1, busy never set; the same stimulus with flush=1 -> HI unchanged.
REQ-033 reset_n low in cycle 3 of a mult -> busy=0, HI=LO=0 immediately.
REQ-034 d_uses_mdu=1 during busy -> stall_req=1 until busy falls.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
// Holds the MDU operation encodings used by both the main decoder and
// mdu_ctrl. It also holds the controller state encoding, the default
// latencies and the busy-counter width.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;
  localparam int MDU_CNT_W        = 4;

  // True for the long-running operations that occupy the unit.
  function automatic logic mdu_is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {HI,LO} result generator.
// Ports:
//   op         - MDU operation code
//   rs_val     - dividend / multiplicand
//   rt_val     - divisor / multiplier
//   result     - {HI,LO}: 64-bit product, or {remainder, quotient}
//   result_vld - 0 for divide-by-zero (HI/LO must stay unchanged) and non-arith ops
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        result_vld
);

  logic               signed_op;
  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [32:0] b_div;
  logic signed [63:0] a64;
  logic signed [63:0] b64;
  logic signed [63:0] prod;
  logic signed [32:0] quot;
  logic signed [32:0] rem;
  logic               unused_arith;

  // One 33-bit signed datapath serves both signed and unsigned forms.
  // The unsigned ops zero-extend, the signed ops sign-extend.
  // Doing the division at 33 bits also gives -2^31 / -1 a defined
  // result (0x80000000 after truncation).
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_ext     = {signed_op & rs_val[31], rs_val};
  assign b_ext     = {signed_op & rt_val[31], rt_val};
  assign a64       = 64'(a_ext);
  assign b64       = 64'(b_ext);
  assign prod      = a64 * b64;

  // Dummy divisor on zero keeps the divider free of X; the result is discarded.
  assign b_div = (rt_val == 32'd0) ? 33'sd1 : b_ext;
  assign quot  = a_ext / b_div;
  assign rem   = a_ext % b_div;

  assign unused_arith = ^{quot[32], rem[32]};

  always_comb begin
    result     = 64'd0;
    result_vld = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        result     = prod;
        result_vld = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        result     = {rem[31:0], quot[31:0]};
        result_vld = (rt_val != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   start, op            - E-stage MDU enable and operation code
//   rs_val, rt_val       - forwarded operands
//   flush                - cancel for the E-stage instruction (not for a running op)
//   d_uses_mdu           - D-stage instruction reads or uses the MDU
//   busy                 - multiply/divide in progress
//   stall_req            - D-stage stall request (combinational)
//   hi, lo               - architectural HI/LO registers
// The result is computed at the accepting edge and held as pending.
// It is committed to HI/LO only once the latency has elapsed.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_uses_mdu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_LAT - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_LAT - 1);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic [63:0]          pend_q, pend_d;
  logic                 pend_ok_q, pend_ok_d;

  logic [63:0]          arith_res;
  logic                 arith_vld;
  logic                 accept;

  mdu_arith u_arith (
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .result     (arith_res),
    .result_vld (arith_vld)
  );

  // Codes 0 and 7 are not operations and never start anything.
  assign accept = start && !flush && (state_q == ST_IDLE) &&
                  (op != MDU_NONE) && (op <= MDU_MTLO);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              state_d   = ST_BUSY;
              cnt_d     = MULT_CNT;
              pend_d    = arith_res;
              pend_ok_d = arith_vld;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d   = ST_BUSY;
              cnt_d     = DIV_CNT;
              pend_d    = arith_res;
              pend_ok_d = arith_vld;
            end
            MDU_MTHI: hi_d = rs_val;
            MDU_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Last busy cycle; a divide-by-zero leaves HI/LO untouched.
          state_d = ST_IDLE;
          if (pend_ok_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign stall_req = d_uses_mdu & (busy | (start & ~flush & mdu_is_muldiv(op)));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: behavioural model (remaining-busy-cycle count plus
// 64-bit reference arithmetic) checked every cycle, with directed
// literal checks and a randomized phase.
module tb_mdu_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_uses_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .d_uses_mdu (d_uses_mdu),
    .busy       (busy),
    .stall_req  (stall_req),
    .hi         (hi),
    .lo         (lo)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: architectural HI/LO, busy cycles still to come, pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_left = 0;
  logic [63:0] m_res = '0;
  bit          m_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, output bit ok);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok  = 1'b1;
    res = '0;
    case (o)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = ua * ub;
      OP_DIV: begin
        if (b == 0) ok = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) ok = 1'b0;
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: ok = 1'b0;
    endcase
    return res;
  endfunction

  // One clock cycle: check outputs at the negedge, drive inputs, check the
  // combinational stall, then advance the model across the rising edge.
  task automatic step(input bit st, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit fl, input bit du);
    bit   exp_busy;
    bit   ok;
    logic [63:0] r;
    @(negedge clk);
    exp_busy = (m_left > 0);
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    start = st; op = o; rs_val = a; rt_val = b; flush = fl; d_uses_mdu = du;
    #1;
    chk("stall_req", {31'd0, stall_req},
        {31'd0, du && (exp_busy || (st && !fl && o >= OP_MULT && o <= OP_DIVU))});
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) {m_hi, m_lo} = m_res;
    end else if (st && !fl && o != OP_NONE && o <= OP_MTLO) begin
      case (o)
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: begin
          r = ref_result(o, a, b, ok);
          m_res = r;
          m_ok = ok;
          m_left = (o == OP_MULT || o == OP_MULTU) ? ML : DL;
        end
      endcase
    end
  endtask

  task automatic idle(input int n, input bit fl, input bit du);
    for (int i = 0; i < n; i++) step(1'b0, OP_NONE, 32'd0, 32'd0, fl, du);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; op = OP_NONE; rs_val = '0; rt_val = '0;
    flush = 1'b0; d_uses_mdu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // mult: -1 * 2
    step(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    for (int k = 1; k <= ML; k++) begin
      #1 chk("mult_busy_window", {31'd0, busy}, 32'd1);
      idle(1, 1'b0, 1'b0);
    end
    #1;
    chk("mult_busy_end", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // multu: same operands
    step(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    idle(ML, 1'b0, 1'b0);
    #1;
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 with flush and a D-stage MDU user during the busy period
    step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b1);
    for (int k = 1; k <= DL; k++) begin
      #1;
      chk("div_busy_window", {31'd0, busy}, 32'd1);
      chk("div_stall_window", {31'd0, stall_req}, 32'd1);
      idle(1, 1'b1, 1'b1);
    end
    #1;
    chk("div_busy_end", {31'd0, busy}, 32'd0);
    chk("div_stall_end", {31'd0, stall_req}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero leaves HI/LO alone after the full busy period
    step(1'b1, OP_MTHI, 32'h11, 32'h0, 1'b0, 1'b0);
    step(1'b1, OP_MTLO, 32'h22, 32'h0, 1'b0, 1'b0);
    step(1'b1, OP_DIVU, 32'h5, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= DL; k++) begin
      #1 chk("divz_busy_window", {31'd0, busy}, 32'd1);
      idle(1, 1'b0, 1'b0);
    end
    #1;
    chk("divz_busy_end", {31'd0, busy}, 32'd0);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // mthi, then the same with flush
    step(1'b1, OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0);
    #1;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'h22);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b1, OP_MTHI, 32'h9999, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mthi_flush_hi", hi, 32'h1234);

    // asynchronous reset in cycle 3 of a mult
    step(1'b1, OP_MULT, 32'h7, 32'h9, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0; m_left = 0; m_res = '0; m_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // first op after reset behaves normally
    step(1'b1, OP_MULT, 32'h3, 32'h4, 1'b0, 1'b0);
    idle(ML, 1'b0, 1'b0);
    #1;
    chk("post_rst_lo", lo, 32'd12);
    chk("post_rst_hi", hi, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_val();
      step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 6)), rnd_val(), b,
           $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1);
    end
    idle(DL + 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
